mac_pipe: RTL and testbench
===========================

// Module: mac_pipe
// PURPOSE
//  Parametrised 3-stage pipelined multiply-accumulate unit for the arithmetic datapath.
//  Each accepted beat either computes A*B+C or accumulates A*B into an internal
//  saturating accumulator. Valid/ready handshakes on both sides allow it to sit
//  between producer and consumer stages that can stall.
// PARAMETERS
//  WIDTH  8  width of operands a, b, c (unsigned)
//  GUARD  4  extra accumulator/result bits above 2*WIDTH; must be >= 1
//  OUT_W  2*WIDTH+GUARD  result/accumulator width (derived localparam, not overridable)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  in_mode    in   2      operation for this beat (mac_mode_t)
//  in_a       in   WIDTH  multiplicand
//  in_b       in   WIDTH  multiplier
//  in_c       in   WIDTH  addend / accumulator seed
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_data   out  OUT_W  result
//  out_ovf    out  1      sticky accumulator-saturation flag
// BEHAVIOUR
//  Reset: all stage valids=0, acc=0, out_data=0, out_valid=0, out_ovf=0.
//    In-flight beats are discarded. rst wins over every other event in the same cycle.
//  Handshake:
//    - A beat transfers when in_valid&&in_ready; a result transfers when out_valid&&out_ready.
//    - Global pipeline enable en = !out_valid || out_ready; in_ready = en
//      (combinational from out_ready).
//    - While !en, all stages and acc hold; out_data/out_valid stay stable.
//  Latency:
//    - Beat accepted at posedge t -> out_valid at posedge t+3 if never stalled.
//    - Throughput 1 beat/cycle. Bubbles propagate as valid=0.
//  Stages:
//    - S1 registers a, b, c, mode, valid.
//    - S2 registers p=a*b (2*WIDTH) plus c, mode, valid.
//    - S3 computes the result and loads out_data/acc.
//  Modes (all widths zero-extended to OUT_W):
//    MADD(00):    out = p + c; acc unchanged. Cannot overflow because GUARD >= 1.
//    ACC(01):     s = acc + p; if s > 2^OUT_W-1 then s = all-ones and out_ovf <= 1.
//                 acc <= s; out = s.
//    ACC_CLR(10): acc <= p + c; out = p + c; out_ovf <= 0.
//    RSVD(11):    behaves as MADD.
//  Dependencies:
//    - acc is read and written only in S3, so back-to-back ACC beats need no hazard stall.
//    - A saturated acc stays at all-ones under further ACC beats.
//  S3 loads only when en && s2_valid. A bubble with en=1 clears out_valid and holds out_data.
// STRUCTURE
//  - Package mac_pkg: typedef enum logic [1:0] mac_mode_t {MADD, ACC, ACC_CLR, RSVD};
//    default WIDTH/GUARD constants.
//  - Sub-module mac_sat_add (OUT_W): unsigned add with saturation and overflow output,
//    used in S3.
//  - Everything else lives in mac_pipe.
// TESTING (WIDTH=8, GUARD=4, OUT_W=20, max 1048575)
//  1. MADD a=3,b=4,c=5, out_ready=1 -> out_data=17 exactly 3 cycles after accept; out_ovf=0.
//  2. Streaming: 10 back-to-back MADD beats with no stall -> 10 consecutive out_valid
//     cycles, correct results, in_ready held 1.
//  3. ACC_CLR a=2,b=3,c=1 then ACC a=4,b=5 then ACC a=1,b=1 -> outputs 7, 27, 28.
//  4. ACC_CLR a=255,b=255,c=0 then 16x ACC a=255,b=255 -> 15th ACC gives 1040400;
//     16th gives 1048575 with out_ovf=1; further ACC holds 1048575; next ACC_CLR clears out_ovf.
//  5. Backpressure: out_ready=0 for 5 cycles with 4 beats offered -> in_ready=0 once
//     out_valid=1; out_data stable; no beat lost or duplicated after out_ready=1.
//  6. rst asserted with 3 beats in flight and acc=500 -> next cycle out_valid=0, acc=0,
//     out_ovf=0; a later ACC a=1,b=1 yields 1.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared operation codes and default sizes for the MAC pipeline
package mac_pkg;

   typedef enum logic [1:0] {
      MADD    = 2'b00,
      ACC     = 2'b01,
      ACC_CLR = 2'b10,
      RSVD    = 2'b11
   } mac_mode_t;

   localparam int MAC_WIDTH = 8;
   localparam int MAC_GUARD = 4;

endpackage

// File: rtl/mac_sat_add.sv
// rtl/mac_sat_add.sv - unsigned adder that clamps to all-ones on carry-out
module mac_sat_add #(
   parameter int OUT_W = 20
) (
   input  logic [OUT_W-1:0] a_i,
   input  logic [OUT_W-1:0] b_i,
   output logic [OUT_W-1:0] sum_o,
   output logic             ovf_o
);

   logic [OUT_W:0] full_sum;

   always_comb begin
      full_sum = {1'b0, a_i} + {1'b0, b_i};
      ovf_o    = full_sum[OUT_W];
      sum_o    = full_sum[OUT_W] ? {OUT_W{1'b1}} : full_sum[OUT_W-1:0];
   end

endmodule

// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - 3-stage multiply-accumulate pipeline with valid/ready on both sides
// S1 captures operands, S2 holds the product, S3 produces the result and owns the accumulator.
module mac_pipe
   import mac_pkg::*;
#(
   parameter int WIDTH = MAC_WIDTH,
   parameter int GUARD = MAC_GUARD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  mac_mode_t                in_mode,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   input  logic [WIDTH-1:0]         in_c,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*WIDTH+GUARD-1:0] out_data,
   output logic                     out_ovf
);

   localparam int OUT_W = 2*WIDTH + GUARD;

   logic                 en;

   logic                 s1_valid_q;
   logic [WIDTH-1:0]     s1_a_q;
   logic [WIDTH-1:0]     s1_b_q;
   logic [WIDTH-1:0]     s1_c_q;
   mac_mode_t            s1_mode_q;

   logic                 s2_valid_q;
   logic [2*WIDTH-1:0]   s2_p_q;
   logic [WIDTH-1:0]     s2_c_q;
   mac_mode_t            s2_mode_q;

   logic                 out_valid_q, out_valid_d;
   logic [OUT_W-1:0]     out_data_q, out_data_d;
   logic [OUT_W-1:0]     acc_q, acc_d;
   logic                 ovf_q, ovf_d;

   logic [OUT_W-1:0]     p_ext;
   logic [OUT_W-1:0]     c_ext;
   logic [OUT_W-1:0]     add_a;
   logic [OUT_W-1:0]     add_b;
   logic [OUT_W-1:0]     sum;
   logic                 sum_ovf;

   // A single enable stalls every stage together, so nothing inside can be overwritten.
   assign en       = !out_valid_q || out_ready;
   assign in_ready = en;

   always_ff @(posedge clk) begin
      if (en) begin
         s1_a_q    <= in_a;
         s1_b_q    <= in_b;
         s1_c_q    <= in_c;
         s1_mode_q <= in_mode;
         s2_p_q    <= {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};
         s2_c_q    <= s1_c_q;
         s2_mode_q <= s1_mode_q;
      end
   end

   assign p_ext = {{GUARD{1'b0}}, s2_p_q};
   assign c_ext = {{(OUT_W-WIDTH){1'b0}}, s2_c_q};

   // ACC adds the product to the accumulator; every other mode adds the addend.
   always_comb begin
      add_a = p_ext;
      add_b = c_ext;
      if (s2_mode_q == ACC) begin
         add_a = acc_q;
         add_b = p_ext;
      end
   end

   mac_sat_add #(
      .OUT_W (OUT_W)
   ) u_sat_add (
      .a_i   (add_a),
      .b_i   (add_b),
      .sum_o (sum),
      .ovf_o (sum_ovf)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      if (en) begin
         out_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            out_data_d = sum;
            case (s2_mode_q)
               ACC: begin
                  acc_d = sum;
                  ovf_d = ovf_q | sum_ovf;
               end
               ACC_CLR: begin
                  acc_d = sum;
                  ovf_d = 1'b0;
               end
               default: begin
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         if (en) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
         end
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// tb/tb_mac_pipe.sv - directed scoreboard bench for mac_pipe
module tb_mac_pipe;
   import mac_pkg::*;

   localparam int WIDTH = 8;
   localparam int GUARD = 4;
   localparam int OUT_W = 2*WIDTH + GUARD;
   localparam logic [OUT_W-1:0] MAXV = {OUT_W{1'b1}};

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   mac_mode_t        in_mode;
   logic [WIDTH-1:0] in_a, in_b, in_c;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_ovf;

   mac_pipe #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OUT_W-1:0] data;
      logic             ovf;
      int               cyc;
   } exp_t;

   exp_t             sb_q[$];
   logic [OUT_W-1:0] got_q[$];
   logic             got_ovf_q[$];

   int               tests = 0;
   int               fails = 0;
   int               cyc = 0;
   int               last_lat = 0;
   int               run = 0;
   int               max_run = 0;
   int               bi;
   int               c_start;
   logic [OUT_W-1:0] m_acc = '0;
   logic             m_ovf = 1'b0;
   logic             accepted;
   logic             stall_prev = 1'b0;
   logic [OUT_W-1:0] stall_data = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_push();
      logic [OUT_W-1:0] p, s;
      logic [OUT_W:0]   full;
      p = OUT_W'(in_a) * OUT_W'(in_b);
      case (in_mode)
         ACC: begin
            full = {1'b0, m_acc} + {1'b0, p};
            if (full > {1'b0, MAXV}) begin
               s     = MAXV;
               m_ovf = 1'b1;
            end else begin
               s = full[OUT_W-1:0];
            end
            m_acc = s;
         end
         ACC_CLR: begin
            s     = p + OUT_W'(in_c);
            m_acc = s;
            m_ovf = 1'b0;
         end
         default: s = p + OUT_W'(in_c);
      endcase
      sb_q.push_back('{data: s, ovf: m_ovf, cyc: cyc});
   endtask

   // One clock: observe at negedge, then advance to just after the next posedge.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      accepted = 1'b0;
      if (rst) begin
         sb_q.delete();
         m_acc      = '0;
         m_ovf      = 1'b0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, stall_data);
         end
         check("in_ready", in_ready, !(out_valid && !out_ready));
         stall_prev = out_valid && !out_ready;
         stall_data = out_data;
         run = out_valid ? run + 1 : 0;
         if (run > max_run) max_run = run;
         if (out_valid && out_ready) begin
            check("sb_has_entry", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check("data", out_data, e.data);
               check("ovf", out_ovf, e.ovf);
               last_lat = cyc - e.cyc;
               got_q.push_back(out_data);
               got_ovf_q.push_back(out_ovf);
            end
         end
         if (in_valid && in_ready) begin
            model_push();
            accepted = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input mac_mode_t m, input int a, input int b, input int c);
      in_valid = 1'b1;
      in_mode  = m;
      in_a     = a[WIDTH-1:0];
      in_b     = b[WIDTH-1:0];
      in_c     = c[WIDTH-1:0];
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (accepted) break;
      end
      check("accept_timeout", accepted, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         if (sb_q.size() == 0) break;
         cycle();
      end
      check("drain", sb_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_mode   = MADD;
      in_a      = '0;
      in_b      = '0;
      in_c      = '0;
      out_ready = 1'b1;
      repeat (3) cycle();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      cycle();

      // single MADD, latency
      got_q.delete(); got_ovf_q.delete();
      send(MADD, 3, 4, 5);
      drain();
      check("t1_data", got_q[0], 17);
      check("t1_ovf", got_ovf_q[0], 0);
      check("t1_latency", last_lat, 3);
      check("t1_bubble", out_valid, 0);

      // streaming
      run = 0; max_run = 0;
      c_start = cyc;
      for (int i = 0; i < 10; i++) begin
         send(MADD, i*7 + 1, 200 - i*3, i*11);
         check("t2_in_ready", in_ready, 1);
      end
      check("t2_back_to_back", cyc - c_start, 10);
      drain();
      check("t2_run", max_run, 10);

      // accumulate chain
      got_q.delete(); got_ovf_q.delete();
      send(ACC_CLR, 2, 3, 1);
      send(ACC, 4, 5, 0);
      send(ACC, 1, 1, 0);
      drain();
      check("t3_clr", got_q[0], 7);
      check("t3_acc1", got_q[1], 27);
      check("t3_acc2", got_q[2], 28);

      // saturation
      got_q.delete(); got_ovf_q.delete();
      send(ACC_CLR, 255, 255, 0);
      for (int i = 0; i < 17; i++) send(ACC, 255, 255, 0);
      send(ACC_CLR, 1, 1, 0);
      drain();
      check("t4_acc15", got_q[15], 1040400);
      check("t4_acc15_ovf", got_ovf_q[15], 0);
      check("t4_acc16", got_q[16], 1048575);
      check("t4_acc16_ovf", got_ovf_q[16], 1);
      check("t4_acc17", got_q[17], 1048575);
      check("t4_acc17_ovf", got_ovf_q[17], 1);
      check("t4_clr", got_q[18], 1);
      check("t4_clr_ovf", got_ovf_q[18], 0);

      // backpressure
      got_q.delete(); got_ovf_q.delete();
      out_ready = 1'b0;
      bi = 0;
      for (int k = 0; k < 5; k++) begin
         if (bi < 4) begin
            in_valid = 1'b1;
            in_mode  = MADD;
            in_a     = WIDTH'(10 + bi);
            in_b     = 8'd3;
            in_c     = WIDTH'(bi);
         end
         cycle();
         if (accepted) bi++;
      end
      check("t5_out_valid", out_valid, 1);
      check("t5_in_ready_low", in_ready, 0);
      check("t5_accepted", bi, 3);
      out_ready = 1'b1;
      send(MADD, 13, 3, 3);
      drain();
      check("t5_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) check("t5_data", got_q[i], 30 + 4*i);

      // reset with beats in flight
      got_q.delete(); got_ovf_q.delete();
      send(ACC_CLR, 20, 25, 0);
      drain();
      check("t6_seed", got_q[0], 500);
      out_ready = 1'b0;
      send(ACC, 1, 1, 0);
      send(ACC, 1, 1, 0);
      send(ACC, 1, 1, 0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("t6_out_valid", out_valid, 0);
      check("t6_out_ovf", out_ovf, 0);
      check("t6_out_data", out_data, 0);
      check("t6_in_ready", in_ready, 1);
      out_ready = 1'b1;
      got_q.delete(); got_ovf_q.delete();
      send(ACC, 1, 1, 0);
      drain();
      check("t6_acc_after_rst", got_q[0], 1);
      repeat (4) cycle();
      check("t6_no_extra", got_q.size(), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
